// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package ysyx_23060332_ifu_pkg;

  localparam int unsigned IFU_XLEN        = 32;
  localparam int unsigned INST_BUS_W      = 32;
  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam logic [31:0] IFU_RESET_PC    = 32'h8000_0000;
  localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
  localparam logic        JUMP_ENABLE     = 1'b1;

  typedef enum logic [2:0] {
    IFU_IDLE = 3'd0,
    IFU_REQ  = 3'd1,
    IFU_WAIT = 3'd2,
    IFU_HOLD = 3'd3,
    IFU_ERR  = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ysyx_23060332_ifu_pc_next.sv
// Next-PC select: sequential increment or word-aligned redirect target,
// flagging targets whose bit1 is set (bit0 is always dropped, JALR style).
module ysyx_23060332_ifu_pc_next #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_addr,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign_c
);

  logic unused_bit0;
  assign unused_bit0 = jump_addr[0];

  always_comb begin
    next_pc    = pc + XLEN'(4);
    misalign_c = 1'b0;
    if (jump_en) begin
      next_pc    = {jump_addr[XLEN-1:2], 2'b00};
      misalign_c = jump_addr[1];
    end
  end

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: owns the PC, runs one imem read at a time and
// holds the fetched instruction until the downstream stage accepts it.
module ysyx_23060332_ifu
  import ysyx_23060332_ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            imem_rsp_ready,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_addr,
  output logic            misalign,
  output logic            fetch_err
);

  ifu_state_e      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic            misalign_c;

  ysyx_23060332_ifu_pc_next #(
    .XLEN (XLEN)
  ) u_pc_next (
    .pc         (pc),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .next_pc    (next_pc),
    .misalign_c (misalign_c)
  );

  // The PC register doubles as the request address; it only moves on acceptance.
  assign imem_req_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IFU_IDLE;
      pc             <= RESET_PC;
      inst_o         <= ZERO_WORD;
      pc_o           <= RESET_PC;
      imem_req_valid <= 1'b0;
      imem_rsp_ready <= 1'b0;
      inst_valid     <= 1'b0;
      misalign       <= 1'b0;
      fetch_err      <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        IFU_IDLE: begin
          state          <= IFU_REQ;
          imem_req_valid <= 1'b1;
        end
        IFU_REQ: begin
          if (imem_req_ready) begin
            state          <= IFU_WAIT;
            imem_req_valid <= 1'b0;
            imem_rsp_ready <= 1'b1;
          end
        end
        IFU_WAIT: begin
          if (imem_rsp_valid) begin
            imem_rsp_ready <= 1'b0;
            if (imem_rsp_err) begin
              state     <= IFU_ERR;
              fetch_err <= 1'b1;
            end else begin
              state      <= IFU_HOLD;
              inst_o     <= imem_rsp_data;
              pc_o       <= pc;
              inst_valid <= 1'b1;
            end
          end
        end
        IFU_HOLD: begin
          // Redirect inputs matter only in the acceptance cycle.
          if (inst_ready) begin
            state          <= IFU_REQ;
            pc             <= next_pc;
            inst_valid     <= 1'b0;
            imem_req_valid <= 1'b1;
            misalign       <= misalign_c;
          end
        end
        IFU_ERR: begin
          state          <= IFU_ERR;
          imem_req_valid <= 1'b0;
          imem_rsp_ready <= 1'b0;
          inst_valid     <= 1'b0;
          fetch_err      <= 1'b1;
        end
        default: begin
          state          <= IFU_IDLE;
          imem_req_valid <= 1'b0;
          imem_rsp_ready <= 1'b0;
          inst_valid     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Self-checking bench for ysyx_23060332_ifu: memory model plus a PC-sequence
// reference model; a second instance starts near the top of the address space.
module tb_ysyx_23060332_ifu;

  localparam logic [31:0] RST_PC  = 32'h8000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] KEY     = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'h0;
  logic        rsp_err = 1'b0;
  logic        inst_ready = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'h0;

  logic        req_valid, rsp_ready, inst_valid, misalign, fetch_err;
  logic [31:0] req_addr, inst_o, pc_o;
  logic        d1_req_valid, d1_rsp_ready, d1_inst_valid, d1_misalign, d1_fetch_err;
  logic [31:0] d1_req_addr, d1_inst_o, d1_pc_o;

  int errors = 0;
  int checks = 0;

  // memory model knobs
  int stall_cycles = 0;
  int rsp_lat = 0;
  bit inject_err = 1'b0;
  bit nop_mode = 1'b1;
  int req_cnt = 0;
  int rsp_cnt = 0;
  logic [31:0] lat_addr = 32'h0;

  ysyx_23060332_ifu dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data), .imem_rsp_err(rsp_err),
    .imem_rsp_ready(rsp_ready),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_o(inst_o), .pc_o(pc_o),
    .jump_en(jump_en), .jump_addr(jump_addr), .misalign(misalign), .fetch_err(fetch_err)
  );

  ysyx_23060332_ifu #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(d1_req_valid), .imem_req_ready(req_ready), .imem_req_addr(d1_req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data), .imem_rsp_err(rsp_err),
    .imem_rsp_ready(d1_rsp_ready),
    .inst_valid(d1_inst_valid), .inst_ready(inst_ready), .inst_o(d1_inst_o), .pc_o(d1_pc_o),
    .jump_en(jump_en), .jump_addr(jump_addr), .misalign(d1_misalign), .fetch_err(d1_fetch_err)
  );

  always #5 clk = ~clk;

  // Memory: stalls the request, then answers only while the IFU waits for it.
  always @(negedge clk) begin
    if (!rst_n) begin
      req_cnt = 0; rsp_cnt = 0;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
    end else begin
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
      if (req_valid) begin
        req_ready = (req_cnt >= stall_cycles);
        if (req_ready) lat_addr = req_addr;
        req_cnt++;
      end else req_cnt = 0;
      if (rsp_ready) begin
        if (rsp_cnt >= rsp_lat) begin
          rsp_valid = 1'b1;
          rsp_err   = inject_err;
          rsp_data  = nop_mode ? 32'h0000_0013 : (lat_addr ^ KEY);
        end
        rsp_cnt++;
      end else rsp_cnt = 0;
    end
  end

  task automatic do_reset(input int n);
    rst_n = 1'b0; inst_ready = 1'b0; jump_en = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_hold(input int max, output bit to);
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (inst_valid === 1'b1) begin to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic accept(input bit je, input logic [31:0] ja);
    inst_ready = 1'b1; jump_en = je; jump_addr = ja;
    @(negedge clk);
    inst_ready = 1'b0; jump_en = 1'b0; jump_addr = $urandom;
  endtask

  task automatic test_reset();
    stall_cycles = 0; rsp_lat = 0; inject_err = 1'b0; nop_mode = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", req_valid); end
    checks++; if (rsp_ready !== 1'b0) begin errors++; $display("FAIL rst_rsp_ready: got %b want 0", rsp_ready); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
    checks++; if ({misalign, fetch_err} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b want 00", {misalign, fetch_err}); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst_o: got %h want 0", inst_o); end
    checks++; if (pc_o !== RST_PC) begin errors++; $display("FAIL rst_pc_o: got %h want %h", pc_o, RST_PC); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b want 1", req_valid); end
    checks++; if (req_addr !== RST_PC) begin errors++; $display("FAIL first_req_addr: got %h want %h", req_addr, RST_PC); end
    checks++; if ({rsp_ready, inst_valid, misalign, fetch_err} !== 4'b0) begin errors++; $display("FAIL first_others: got %b want 0000", {rsp_ready, inst_valid, misalign, fetch_err}); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    stall_cycles = 0; rsp_lat = 0; nop_mode = 1'b1;
    do_reset(2);
    inst_ready = 1'b1;
    exp_pc = RST_PC;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++; if (inst_valid !== (k % 3 == 0)) begin errors++; $display("FAIL seq_valid_pattern c%0d: got %b want %b", k, inst_valid, (k % 3 == 0)); end
      if (k % 3 == 0) begin
        checks++; if (pc_o !== exp_pc) begin errors++; $display("FAIL seq_pc c%0d: got %h want %h", k, pc_o, exp_pc); end
        checks++; if (inst_o !== 32'h13) begin errors++; $display("FAIL seq_inst c%0d: got %h want 00000013", k, inst_o); end
        exp_pc = exp_pc + 32'd4;
      end
      if (k == 1) begin
        checks++; if (d1_req_addr !== WRAP_PC) begin errors++; $display("FAIL wrap_first_addr: got %h want %h", d1_req_addr, WRAP_PC); end
      end
      if (k == 4) begin
        checks++; if (d1_req_valid !== 1'b1 || d1_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_second_addr: got v=%b %h want v=1 00000000", d1_req_valid, d1_req_addr); end
        checks++; if ({d1_fetch_err, d1_misalign} !== 2'b00) begin errors++; $display("FAIL wrap_flags: got %b want 00", {d1_fetch_err, d1_misalign}); end
      end
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_jump_misalign();
    bit to;
    stall_cycles = 0; rsp_lat = 0; nop_mode = 1'b1;
    do_reset(2);
    for (int i = 0; i < 2; i++) begin
      wait_hold(20, to);
      checks++; if (to) begin errors++; $display("FAIL jump_wait%0d: got timeout want hold", i); end
      accept(1'b0, 32'h0);
    end
    wait_hold(20, to);
    checks++; if (to || pc_o !== 32'h8000_0008) begin errors++; $display("FAIL jump_src_pc: got %h want 80000008", pc_o); end
    accept(1'b1, 32'h8000_0101);
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0100) begin errors++; $display("FAIL jump_addr: got v=%b %h want v=1 80000100", req_valid, req_addr); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL jump_misalign: got %b want 0", misalign); end
    wait_hold(20, to);
    checks++; if (to || pc_o !== 32'h8000_0100) begin errors++; $display("FAIL jump_dst_pc: got %h want 80000100", pc_o); end
    accept(1'b1, 32'h8000_0102);
    checks++; if (req_addr !== 32'h8000_0100) begin errors++; $display("FAIL mis_addr: got %h want 80000100", req_addr); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", misalign); end
    @(negedge clk);
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b want 0", misalign); end
  endtask

  task automatic test_backpressure();
    bit to;
    int n_req;
    logic [31:0] h_inst, h_pc;
    stall_cycles = 4; rsp_lat = 0; nop_mode = 1'b0;
    do_reset(2);
    n_req = 0;
    @(negedge clk);
    for (int i = 0; i < 12 && req_valid === 1'b1; i++) begin
      n_req++;
      checks++; if (req_addr !== RST_PC) begin errors++; $display("FAIL bp_addr_stable c%0d: got %h want %h", i, req_addr, RST_PC); end
      @(negedge clk);
    end
    checks++; if (n_req !== 5) begin errors++; $display("FAIL bp_req_cycles: got %0d want 5", n_req); end
    stall_cycles = 0;
    wait_hold(20, to);
    checks++; if (to) begin errors++; $display("FAIL bp_hold_wait: got timeout want hold"); end
    h_inst = inst_o; h_pc = pc_o;
    checks++; if (h_inst !== (RST_PC ^ KEY)) begin errors++; $display("FAIL bp_inst: got %h want %h", h_inst, RST_PC ^ KEY); end
    for (int i = 0; i < 5; i++) begin
      jump_en = 1'b1; jump_addr = $urandom;
      @(negedge clk);
      checks++; if (inst_valid !== 1'b1 || inst_o !== h_inst || pc_o !== h_pc || req_valid !== 1'b0) begin
        errors++; $display("FAIL bp_hold_stable c%0d: got v=%b %h %h req=%b want v=1 %h %h req=0", i, inst_valid, inst_o, pc_o, req_valid, h_inst, h_pc);
      end
    end
    accept(1'b0, 32'h0);
    checks++; if (req_addr !== RST_PC + 32'd4 || misalign !== 1'b0) begin errors++; $display("FAIL bp_next: got %h mis=%b want %h mis=0", req_addr, misalign, RST_PC + 32'd4); end
  endtask

  task automatic test_error();
    stall_cycles = 0; rsp_lat = 1; inject_err = 1'b1; nop_mode = 1'b1;
    do_reset(2);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      checks++; if (fetch_err !== 1'b1 || req_valid !== 1'b0 || inst_valid !== 1'b0 || rsp_ready !== 1'b0) begin
        errors++; $display("FAIL err_sticky c%0d: got err=%b req=%b iv=%b rr=%b want 1 0 0 0", i, fetch_err, req_valid, inst_valid, rsp_ready);
      end
      @(negedge clk);
    end
    inject_err = 1'b0; rsp_lat = 0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", fetch_err); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_valid !== 1'b1 || req_addr !== RST_PC) begin errors++; $display("FAIL err_restart: got v=%b %h want v=1 %h", req_valid, req_addr, RST_PC); end
  endtask

  task automatic test_random();
    bit to, je;
    logic [31:0] exp_pc, ja;
    bit exp_mis;
    int k;
    nop_mode = 1'b0; inject_err = 1'b0;
    stall_cycles = $urandom_range(0, 3); rsp_lat = $urandom_range(0, 3);
    do_reset(2);
    exp_pc = RST_PC;
    for (int n = 0; n < 40; n++) begin
      wait_hold(40, to);
      checks++; if (to) begin errors++; $display("FAIL rnd_wait n%0d: got timeout want hold", n); end
      checks++; if (pc_o !== exp_pc || inst_o !== (exp_pc ^ KEY)) begin errors++; $display("FAIL rnd_fetch n%0d: got %h/%h want %h/%h", n, pc_o, inst_o, exp_pc, exp_pc ^ KEY); end
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) begin
        jump_en = $urandom_range(0, 1); jump_addr = $urandom;
        @(negedge clk);
        checks++; if (pc_o !== exp_pc) begin errors++; $display("FAIL rnd_stall n%0d: got %h want %h", n, pc_o, exp_pc); end
      end
      je = $urandom_range(0, 1);
      ja = $urandom;
      if (je) exp_pc = {ja[31:2], 2'b00};
      else    exp_pc = exp_pc + 32'd4;
      exp_mis = je && ja[1];
      stall_cycles = $urandom_range(0, 3); rsp_lat = $urandom_range(0, 3);
      accept(je, ja);
      checks++; if (req_valid !== 1'b1 || req_addr !== exp_pc || misalign !== exp_mis) begin
        errors++; $display("FAIL rnd_next n%0d: got v=%b %h mis=%b want v=1 %h mis=%b", n, req_valid, req_addr, misalign, exp_pc, exp_mis);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_jump_misalign();
    test_backpressure();
    test_error();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
